// File: rtl/inst_fetch_queue_pkg.sv
// Shared CPU package for the instruction-fetch path.
// Holds the AXI encoding constants used on the AR channel, the fetch and
// data side AXI IDs, the default reset PC and the per-slot flag record of
// the instruction queue.
package inst_fetch_queue_pkg;

  localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [7:0]  AXI_LEN_1BEAT  = 8'd0;

  localparam int          AXI_FETCH_ID   = 0;
  localparam int          AXI_DATA_ID    = 1;

  localparam logic [31:0] CPU_RESET_PC   = 32'hbfc00000;

  // Per-slot status: filled = instruction word present, adel = address
  // error entry, rerr = bus returned a non-OKAY response.
  typedef struct packed {
    logic filled;
    logic adel;
    logic rerr;
  } slot_flags_t;

endpackage

// File: rtl/inst_fetch_queue_slot_ram.sv
// fetch_slot_ram: QDEPTH-entry storage for the instruction queue.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   flush_i            invalidate every slot (redirect)
//   alloc_*            write pc/flags of a newly allocated slot, clears inst
//   fill_*             write instruction word and rerr, marks slot filled
//   rd_idx_i / rd_*_o  combinational read of one slot (queue head)
module fetch_slot_ram
  import inst_fetch_queue_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int IW     = $clog2(QDEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush_i,
  input  logic          alloc_en_i,
  input  logic [IW-1:0] alloc_idx_i,
  input  logic [31:0]   alloc_pc_i,
  input  logic          alloc_filled_i,
  input  logic          alloc_adel_i,
  input  logic          fill_en_i,
  input  logic [IW-1:0] fill_idx_i,
  input  logic [31:0]   fill_inst_i,
  input  logic          fill_rerr_i,
  input  logic [IW-1:0] rd_idx_i,
  output logic [31:0]   rd_pc_o,
  output logic [31:0]   rd_inst_o,
  output logic          rd_filled_o,
  output logic          rd_adel_o,
  output logic          rd_rerr_o
);

  logic [31:0] pc_q    [QDEPTH];
  logic [31:0] inst_q  [QDEPTH];
  slot_flags_t flags_q [QDEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < QDEPTH; i++) begin
        pc_q[i]    <= '0;
        inst_q[i]  <= '0;
        flags_q[i] <= '0;
      end
    end else if (flush_i) begin
      for (int i = 0; i < QDEPTH; i++) begin
        flags_q[i].filled <= 1'b0;
      end
    end else begin
      // Allocate and fill never target the same slot: a fill only happens
      // for slots allocated in an earlier cycle.
      if (alloc_en_i) begin
        pc_q[alloc_idx_i]    <= alloc_pc_i;
        inst_q[alloc_idx_i]  <= '0;
        flags_q[alloc_idx_i] <= '{filled: alloc_filled_i, adel: alloc_adel_i, rerr: 1'b0};
      end
      if (fill_en_i) begin
        inst_q[fill_idx_i]         <= fill_inst_i;
        flags_q[fill_idx_i].rerr   <= fill_rerr_i;
        flags_q[fill_idx_i].filled <= 1'b1;
      end
    end
  end

  assign rd_pc_o     = pc_q[rd_idx_i];
  assign rd_inst_o   = inst_q[rd_idx_i];
  assign rd_filled_o = flags_q[rd_idx_i].filled;
  assign rd_adel_o   = flags_q[rd_idx_i].adel;
  assign rd_rerr_o   = flags_q[rd_idx_i].rerr;

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: sequential-PC AXI instruction fetch with up to
// MAX_OUTSTANDING single-beat reads in flight and an in-order QDEPTH-entry
// instruction queue feeding decode.
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   redirect_valid, redirect_pc      flush queue and restart fetch
//   ar*                              AXI read-address channel (single beat)
//   r*                               AXI read-data channel (rid filtered)
//   if_valid/pc/inst/adel/rerr       queue head towards decode
//   id_allowin                       decode consumes the head
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int          QDEPTH          = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          ID_W            = 4,
  parameter int          FETCH_ID        = AXI_FETCH_ID,
  parameter logic [31:0] RESET_PC        = CPU_RESET_PC
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            redirect_valid,
  input  logic [31:0]     redirect_pc,
  output logic            arvalid,
  input  logic            arready,
  output logic [31:0]     araddr,
  output logic [ID_W-1:0] arid,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  input  logic            rvalid,
  output logic            rready,
  input  logic [31:0]     rdata,
  input  logic [ID_W-1:0] rid,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  output logic            if_valid,
  output logic [31:0]     if_pc,
  output logic [31:0]     if_inst,
  output logic            if_adel,
  output logic            if_rerr,
  input  logic            id_allowin
);

  localparam int              IW      = $clog2(QDEPTH);
  localparam int              PW      = IW + 1;
  localparam logic [PW-1:0]   ONE     = PW'(1);
  localparam logic [PW-1:0]   DEPTH_P = PW'(QDEPTH);
  localparam logic [PW:0]     MAXO_P  = (PW+1)'(MAX_OUTSTANDING);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   araddr_q, araddr_d;
  logic          arvalid_q, arvalid_d;
  logic          ar_stale_q, ar_stale_d;
  logic          halted_q, halted_d;
  logic          rready_q;
  logic [PW-1:0] head_q, head_d, fill_q, fill_d, tail_q, tail_d;
  logic [PW-1:0] live_q, live_d, discard_q, discard_d;

  logic          ar_hs, ar_pend, r_hs, deq, push_adel, issue_ok;
  logic [PW-1:0] used_q, used_d, stale_sum;
  logic [PW:0]   inflight_d;
  logic          flush, alloc_en, alloc_filled, alloc_adel, fill_en;
  logic [31:0]   alloc_pc;
  logic          rd_filled, rd_adel, rd_rerr;
  logic [31:0]   rd_pc, rd_inst;
  logic          unused_rlast;

  assign unused_rlast = rlast;

  assign ar_hs   = arvalid_q & arready;
  assign ar_pend = arvalid_q & ~arready;
  assign r_hs    = rvalid & rready_q & (rid == ID_W'(FETCH_ID));
  assign deq     = if_valid & id_allowin;
  assign used_q  = tail_q - head_q;

  // A misaligned PC becomes a single address-error entry once every live
  // fetch has landed, so it stays in program order behind them.
  assign push_adel = ~halted_q && (fetch_pc_q[1:0] != 2'b00) &&
                     (live_q == '0) && (used_q < DEPTH_P);

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    halted_d     = halted_q;
    head_d       = head_q;
    fill_d       = fill_q;
    tail_d       = tail_q;
    live_d       = live_q;
    discard_d    = discard_q;
    ar_stale_d   = ar_stale_q;
    flush        = 1'b0;
    alloc_en     = 1'b0;
    alloc_filled = 1'b0;
    alloc_adel   = 1'b0;
    alloc_pc     = araddr_q;
    fill_en      = 1'b0;
    // Everything in flight at a redirect, including an AR accepted right
    // now, becomes stale; a beat landing right now retires one of them.
    stale_sum    = discard_q + live_q + {{(PW-1){1'b0}}, ar_hs};

    if (redirect_valid) begin
      flush      = 1'b1;
      head_d     = '0;
      fill_d     = '0;
      tail_d     = '0;
      live_d     = '0;
      discard_d  = (r_hs && stale_sum != '0) ? stale_sum - ONE : stale_sum;
      fetch_pc_d = redirect_pc;
      halted_d   = 1'b0;
      ar_stale_d = ar_pend;
    end else begin
      ar_stale_d = ar_stale_q & ar_pend;
      if (ar_hs) begin
        if (ar_stale_q) begin
          discard_d = discard_d + ONE;
        end else begin
          alloc_en   = 1'b1;
          tail_d     = tail_q + ONE;
          fetch_pc_d = fetch_pc_q + 32'd4;
          live_d     = live_d + ONE;
        end
      end
      if (r_hs) begin
        if (discard_q != '0) begin
          discard_d = discard_d - ONE;
        end else if (live_q != '0) begin
          fill_en = 1'b1;
          fill_d  = fill_q + ONE;
          live_d  = live_d - ONE;
        end
      end
      if (push_adel) begin
        alloc_en     = 1'b1;
        alloc_filled = 1'b1;
        alloc_adel   = 1'b1;
        alloc_pc     = fetch_pc_q;
        tail_d       = tail_q + ONE;
        fill_d       = fill_q + ONE;
        halted_d     = 1'b1;
      end
      if (deq) begin
        head_d = head_q + ONE;
      end
    end
  end

  // arvalid is registered, so issue is decided on next-state occupancy;
  // a pending AR is held with its address regardless of redirects.
  assign used_d     = tail_d - head_d;
  assign inflight_d = {1'b0, live_d} + {1'b0, discard_d};
  assign issue_ok   = (fetch_pc_d[1:0] == 2'b00) && (used_d < DEPTH_P) &&
                      (inflight_d < MAXO_P) && ~halted_d;
  assign arvalid_d  = ar_pend | issue_ok;
  assign araddr_d   = ar_pend ? araddr_q : fetch_pc_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q <= RESET_PC;
      araddr_q   <= RESET_PC;
      arvalid_q  <= 1'b0;
      ar_stale_q <= 1'b0;
      halted_q   <= 1'b0;
      rready_q   <= 1'b0;
      head_q     <= '0;
      fill_q     <= '0;
      tail_q     <= '0;
      live_q     <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      araddr_q   <= araddr_d;
      arvalid_q  <= arvalid_d;
      ar_stale_q <= ar_stale_d;
      halted_q   <= halted_d;
      rready_q   <= 1'b1;
      head_q     <= head_d;
      fill_q     <= fill_d;
      tail_q     <= tail_d;
      live_q     <= live_d;
      discard_q  <= discard_d;
    end
  end

  fetch_slot_ram #(
    .QDEPTH (QDEPTH),
    .IW     (IW)
  ) u_slot_ram (
    .clk            (clk),
    .resetn         (resetn),
    .flush_i        (flush),
    .alloc_en_i     (alloc_en),
    .alloc_idx_i    (tail_q[IW-1:0]),
    .alloc_pc_i     (alloc_pc),
    .alloc_filled_i (alloc_filled),
    .alloc_adel_i   (alloc_adel),
    .fill_en_i      (fill_en),
    .fill_idx_i     (fill_q[IW-1:0]),
    .fill_inst_i    (rdata),
    .fill_rerr_i    (rresp != 2'b00),
    .rd_idx_i       (head_q[IW-1:0]),
    .rd_pc_o        (rd_pc),
    .rd_inst_o      (rd_inst),
    .rd_filled_o    (rd_filled),
    .rd_adel_o      (rd_adel),
    .rd_rerr_o      (rd_rerr)
  );

  assign arvalid  = arvalid_q;
  assign araddr   = araddr_q;
  assign arid     = ID_W'(FETCH_ID);
  assign arlen    = AXI_LEN_1BEAT;
  assign arsize   = AXI_SIZE_4B;
  assign arburst  = AXI_BURST_INCR;
  assign rready   = rready_q;
  assign if_valid = rd_filled & (head_q != tail_q);
  assign if_pc    = rd_pc;
  assign if_inst  = rd_inst;
  assign if_adel  = rd_adel;
  assign if_rerr  = rd_rerr;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue (QDEPTH=4, MAX_OUTSTANDING=2): a cycle
// table of directed vectors plus hand-written multi-cycle sequences.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [3:0]  rid;
  logic [1:0]  rresp;
  logic        rlast;
  logic        if_valid, if_adel, if_rerr, id_allowin;
  logic [31:0] if_pc, if_inst;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  inst_fetch_queue #(
    .QDEPTH(4), .MAX_OUTSTANDING(2), .ID_W(4), .FETCH_ID(0), .RESET_PC(32'hbfc00000)
  ) dut (
    .clk(clk), .resetn(resetn),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid),
    .rresp(rresp), .rlast(rlast),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_adel(if_adel), .if_rerr(if_rerr), .id_allowin(id_allowin)
  );

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        ardy;
    logic        rv;
    logic [31:0] rd;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic        allow;
    logic        e_arv;
    logic [31:0] e_addr;
    logic        e_ifv;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_rerr;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    redirect_valid = 1'b0; redirect_pc = 32'h0; arready = 1'b0;
    rvalid = 1'b0; rdata = 32'h0; rid = 4'h0; rresp = 2'b00; rlast = 1'b1;
    id_allowin = 1'b0;
  endtask

  // One clock edge; sampling happens 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    resetn = 1'b0;
    #1;
    chk("rst arvalid", arvalid, 0);
    chk("rst if_valid", if_valid, 0);
    repeat (2) cyc();
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic beat;
    int   nar;

    //           redir rpc           rdy  rv   rdata         id    resp   allow  arv  araddr        ifv  pc            inst          rerr
    vecs[0]  = '{1'b0, 32'h0,        1'b1,1'b0,32'h0,        4'h0, 2'b00, 1'b0,  1'b1,32'hbfc00000, 1'b0,32'h0,        32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h0,        1'b1,1'b0,32'h0,        4'h0, 2'b00, 1'b0,  1'b1,32'hbfc00004, 1'b0,32'h0,        32'h0,        1'b0};
    vecs[2]  = '{1'b0, 32'h0,        1'b1,1'b1,32'h24020001, 4'h0, 2'b00, 1'b0,  1'b1,32'hbfc00008, 1'b1,32'hbfc00000, 32'h24020001, 1'b0};
    vecs[3]  = '{1'b0, 32'h0,        1'b1,1'b1,32'h24020002, 4'h0, 2'b00, 1'b1,  1'b1,32'hbfc0000c, 1'b1,32'hbfc00004, 32'h24020002, 1'b0};
    vecs[4]  = '{1'b1, 32'h80000100, 1'b1,1'b1,32'h24020003, 4'h0, 2'b00, 1'b1,  1'b1,32'h80000100, 1'b0,32'h0,        32'h0,        1'b0};
    vecs[5]  = '{1'b0, 32'h0,        1'b0,1'b1,32'hdeadbeef, 4'h0, 2'b00, 1'b1,  1'b1,32'h80000100, 1'b0,32'h0,        32'h0,        1'b0};
    vecs[6]  = '{1'b0, 32'h0,        1'b1,1'b0,32'h0,        4'h0, 2'b00, 1'b0,  1'b1,32'h80000104, 1'b0,32'h0,        32'h0,        1'b0};
    vecs[7]  = '{1'b0, 32'h0,        1'b0,1'b1,32'h11111111, 4'h0, 2'b00, 1'b0,  1'b1,32'h80000104, 1'b1,32'h80000100, 32'h11111111, 1'b0};
    vecs[8]  = '{1'b0, 32'h0,        1'b0,1'b0,32'h0,        4'h0, 2'b00, 1'b1,  1'b1,32'h80000104, 1'b0,32'h0,        32'h0,        1'b0};
    vecs[9]  = '{1'b0, 32'h0,        1'b1,1'b1,32'haaaaaaaa, 4'h1, 2'b00, 1'b0,  1'b1,32'h80000108, 1'b0,32'h0,        32'h0,        1'b0};
    vecs[10] = '{1'b0, 32'h0,        1'b0,1'b1,32'h22222222, 4'h0, 2'b10, 1'b0,  1'b1,32'h80000108, 1'b1,32'h80000104, 32'h22222222, 1'b1};
    vecs[11] = '{1'b0, 32'h0,        1'b0,1'b1,32'h33333333, 4'h1, 2'b00, 1'b0,  1'b1,32'h80000108, 1'b1,32'h80000104, 32'h22222222, 1'b1};

    idle();
    #2;
    do_reset();
    chk("rst rready", rready, 0);
    chk("rst araddr", araddr, 32'hbfc00000);
    chk("rst if_pc", if_pc, 0);
    chk("rst if_inst", if_inst, 0);
    chk("rst if_adel", if_adel, 0);
    chk("rst if_rerr", if_rerr, 0);
    chk("arid", arid, 0);
    chk("arlen", arlen, 0);
    chk("arsize", arsize, 3'b010);
    chk("arburst", arburst, 2'b01);

    // Cycle table: basic fetch, redirect with a same-cycle beat and AR,
    // stale drop, rid filtering and rresp error.
    for (int i = 0; i < 12; i++) begin
      redirect_valid = vecs[i].redir; redirect_pc = vecs[i].rpc;
      arready = vecs[i].ardy; rvalid = vecs[i].rv; rdata = vecs[i].rd;
      rid = vecs[i].id; rresp = vecs[i].resp; id_allowin = vecs[i].allow;
      cyc();
      if (i == 0) chk("rready after reset", rready, 1);
      chk($sformatf("row%0d arvalid", i), arvalid, vecs[i].e_arv);
      if (vecs[i].e_arv) chk($sformatf("row%0d araddr", i), araddr, vecs[i].e_addr);
      chk($sformatf("row%0d if_valid", i), if_valid, vecs[i].e_ifv);
      if (vecs[i].e_ifv) begin
        chk($sformatf("row%0d if_pc", i), if_pc, vecs[i].e_pc);
        chk($sformatf("row%0d if_inst", i), if_inst, vecs[i].e_inst);
        chk($sformatf("row%0d if_rerr", i), if_rerr, vecs[i].e_rerr);
        chk($sformatf("row%0d if_adel", i), if_adel, 0);
      end
    end

    // Queue full: decode stalled, responder answers one cycle after each AR.
    do_reset();
    arready = 1'b1;
    beat = 1'b0;
    nar = 0;
    for (int c = 0; c < 12; c++) begin
      rvalid = beat;
      rdata = 32'h1000 + c;
      beat = arvalid && arready;
      if (beat) nar++;
      cyc();
    end
    rvalid = 1'b0;
    chk("full ar count", nar, 4);
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("full arvalid low", arvalid, 0);
    end
    chk("full head pc", if_pc, 32'hbfc00000);
    chk("full head valid", if_valid, 1);
    arready = 1'b0;
    id_allowin = 1'b1;
    cyc();
    id_allowin = 1'b0;
    chk("full deq arvalid", arvalid, 1);
    chk("full deq araddr", araddr, 32'hbfc00010);
    chk("full deq next pc", if_pc, 32'hbfc00004);

    // Redirect while an AR is stalled on arready.
    do_reset();
    cyc();
    chk("hold arvalid", arvalid, 1);
    redirect_valid = 1'b1; redirect_pc = 32'h80000200;
    cyc();
    redirect_valid = 1'b0;
    chk("hold araddr redir", araddr, 32'hbfc00000);
    chk("hold arvalid redir", arvalid, 1);
    cyc();
    chk("hold araddr later", araddr, 32'hbfc00000);
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    chk("hold next arvalid", arvalid, 1);
    chk("hold next araddr", araddr, 32'h80000200);
    rvalid = 1'b1; rdata = 32'hbad0bad0;
    cyc();
    rvalid = 1'b0;
    chk("hold stale dropped", if_valid, 0);
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h00000005;
    cyc();
    rvalid = 1'b0;
    chk("hold new valid", if_valid, 1);
    chk("hold new pc", if_pc, 32'h80000200);
    chk("hold new inst", if_inst, 32'h00000005);

    // Misaligned redirect: address-error entry, then halted until redirect.
    do_reset();
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h80000102;
    cyc();
    redirect_valid = 1'b0;
    chk("adel pending araddr", araddr, 32'hbfc00000);
    chk("adel not yet valid", if_valid, 0);
    cyc();
    chk("adel valid", if_valid, 1);
    chk("adel flag", if_adel, 1);
    chk("adel pc", if_pc, 32'h80000102);
    chk("adel inst", if_inst, 0);
    arready = 1'b1;
    cyc();
    chk("adel no new ar", arvalid, 0);
    rvalid = 1'b1; rdata = 32'h77777777;
    cyc();
    rvalid = 1'b0;
    chk("adel entry kept", if_pc, 32'h80000102);
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("adel halted arvalid", arvalid, 0);
    end
    id_allowin = 1'b1;
    cyc();
    id_allowin = 1'b0;
    chk("adel dequeued", if_valid, 0);
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("adel idle arvalid", arvalid, 0);
      chk("adel idle if_valid", if_valid, 0);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h80000300;
    cyc();
    redirect_valid = 1'b0;
    chk("adel resume arvalid", arvalid, 1);
    chk("adel resume araddr", araddr, 32'h80000300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
